gravity_ctrl: RTL
=================

GRAVITY_CTRL -- requirements
Module: gravity_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 3: number of platform lines; lines[k] enables line k.
REQ-002 Parameter Y_W, default 9: height width in bits.
REQ-003 Parameter DN_OFFSET, default 120: standing height on line 0 under downward gravity.
REQ-004 Parameter UP_OFFSET, default 60: standing height on line 0 under upward gravity.
REQ-005 Parameter PITCH, default 120: height spacing between adjacent lines.
REQ-006 Parameter BUF_WIN, default 8: cycles an airborne switch request stays buffered; range 1..255.
REQ-007 Parameter COOLDOWN, default 4: cycles after a flip during which requests are ignored; range 0..255.
REQ-008 Parameter CNT_W, default 8: flip_count width.
REQ-009 clk  input  1  clock; all state updates on the rising edge.
REQ-010 reset  input  1  synchronous, active-low reset.
REQ-011 is_dead  input  1  1 = player dead; freezes block state.
REQ-012 switch  input  1  gravity-flip button, level.
REQ-013 lines  input  NUM_LINES  per-line present mask.
REQ-014 height  input  Y_W  player height.
REQ-015 dir  output  1  0 = downward gravity, 1 = upward gravity; registered.
REQ-016 grounded  output  1  combinational; player is standing on an enabled line for the current dir.
REQ-017 flip  output  1  registered; 1-cycle pulse in the cycle after dir toggles.
REQ-018 busy  output  1  registered; 1 while state is BUFFERED or COOLDOWN.
REQ-019 flip_count  output  CNT_W  registered count of flips; saturates at all-ones.

Function
REQ-020 grounded SHALL be 1 when there exists k with lines[k]=1 and either dir=0 and height==DN_OFFSET+k*PITCH, or dir=1 and height==UP_OFFSET+k*PITCH. The comparison SHALL be at least Y_W+1 bits wide, so that no sum wraps.
REQ-021 switch_q SHALL register switch every cycle, including while is_dead=1. The request edge is switch=1 with switch_q=0.
REQ-022 The state machine SHALL have the states IDLE, BUFFERED and COOLDOWN, plus an 8-bit timer.
REQ-023 IDLE: on an edge with grounded=1, toggle dir and go to COOLDOWN with timer=COOLDOWN. If COOLDOWN=0, stay in IDLE instead.
REQ-024 IDLE: on an edge with grounded=0, go to BUFFERED with timer=BUF_WIN-1.
REQ-025 BUFFERED: if grounded=1, toggle dir and go to COOLDOWN (or IDLE if COOLDOWN=0). This takes priority over any edge in the same cycle.
REQ-026 BUFFERED: if grounded=0 and an edge occurs, reload timer=BUF_WIN-1. Otherwise, if timer=0, go to IDLE with no flip; else decrement timer.
REQ-027 COOLDOWN: all edges SHALL be ignored (not buffered). If timer<=1, go to IDLE; else decrement timer.
REQ-028 Flip latency SHALL be 1 cycle: a qualifying cycle t gives the new dir at edge t+1 and flip=1 during cycle t+1 only.
REQ-029 Every toggle SHALL increment flip_count by 1 unless it is all-ones (saturate).
REQ-030 While is_dead=1, dir, state, timer and flip_count SHALL hold, and flip SHALL be 0. Edges seen while dead are lost.
REQ-031 The block SHALL flip only between enabled lines; gravity changes never depend on disabled line bits.

Reset
REQ-032 When reset=0 at a clock edge, the block SHALL set dir=0, state=IDLE, timer=0, flip=0, busy=0, flip_count=0, and switch_q=1 (a button held through reset does not fire).
REQ-033 Reset SHALL take priority over is_dead and abandon any buffered or cooldown operation mid-way.
REQ-034 Without a reset edge, the power-up value SHALL match the reset values.

Verification (defaults)
REQ-035 height=120, lines=3'b001, dir=0, switch 0->1 -> dir=1 and flip=1 next cycle; busy=1 for 4 cycles; flip_count=1.
REQ-036 height=100 (airborne), switch pulse, then height=240 with lines[1]=1 three cycles later -> dir toggles the cycle after grounded; flip_count=1.
REQ-037 Airborne switch pulse, player never grounded for 8 cycles -> state returns to IDLE, dir unchanged, flip never asserted.
REQ-038 A flip, then switch re-pressed during cooldown while grounded at height 180 with lines[1]=1 -> no second flip; a re-press after cooldown flips dir back to 0.
REQ-039 is_dead=1 during a BUFFERED request, then grounded -> no flip while dead; timer and state hold and resume when is_dead returns to 0.
REQ-040 switch held high through reset=0, then released and re-pressed -> only the re-press flips; CNT_W=2 with 5 flips -> flip_count=3.

Source files
------------

// File: rtl/gravity_ctrl.sv
// -----------------------------------------------------------------------------
// gravity_ctrl
//
// Gravity-flip controller for a platformer character. A rising edge on the
// switch button toggles gravity direction when the player is standing on an
// enabled platform line. If the player is airborne, the request is buffered
// for BUF_WIN cycles and fires as soon as the player lands. After every flip,
// a COOLDOWN window ignores further presses. While the player is dead, all
// control state is frozen.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   synchronous, active-low reset
//   is_dead     in   1 = player dead; freezes dir/state/timer/flip_count
//   switch      in   gravity-flip button (level)
//   lines       in   [NUM_LINES] per-line present mask
//   height      in   [Y_W] player height
//   dir         out  0 = downward gravity, 1 = upward gravity (registered)
//   grounded    out  player stands on an enabled line for current dir (comb.)
//   flip        out  1-cycle pulse in the cycle after dir toggles (registered)
//   busy        out  1 while a request is buffered or cooldown is running
//   flip_count  out  [CNT_W] saturating count of flips (registered)
// -----------------------------------------------------------------------------
module gravity_ctrl #(
  parameter int NUM_LINES = 3,
  parameter int Y_W       = 9,
  parameter int DN_OFFSET = 120,
  parameter int UP_OFFSET = 60,
  parameter int PITCH     = 120,
  parameter int BUF_WIN   = 8,    // 1..255
  parameter int COOLDOWN  = 4,    // 0..255
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_dead,
  input  logic                 switch,
  input  logic [NUM_LINES-1:0] lines,
  input  logic [Y_W-1:0]       height,
  output logic                 dir,
  output logic                 grounded,
  output logic                 flip,
  output logic                 busy,
  output logic [CNT_W-1:0]     flip_count
);

  // Height comparisons run at least one bit wider than the height input so
  // that offset + k*PITCH never wraps back into the valid height range.
  localparam int CMP_W = (Y_W >= 32) ? Y_W + 1 : 32;

  localparam logic       HAS_COOLDOWN = (COOLDOWN != 0);
  localparam logic [7:0] BUF_RELOAD   = 8'(BUF_WIN - 1);
  localparam logic [7:0] CD_RELOAD    = 8'(COOLDOWN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUFFERED = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  // Where the machine lands after a flip: with no cooldown window there is
  // nothing to wait for, so it goes straight back to idle.
  localparam state_t     FLIP_STATE = HAS_COOLDOWN ? S_COOLDOWN : S_IDLE;
  localparam logic [7:0] FLIP_TIMER = HAS_COOLDOWN ? CD_RELOAD : 8'd0;

  // NOTE: declaration initializers give the registers their reset values at
  // power-up, so the block behaves identically with or without a reset edge.
  state_t           state    = S_IDLE;
  logic [7:0]       timer    = 8'd0;
  logic             dir_r    = 1'b0;
  logic             flip_r   = 1'b0;
  logic             busy_r   = 1'b0;
  logic [CNT_W-1:0] cnt_r    = '0;
  logic             switch_q = 1'b1;

  state_t           state_d;
  logic [7:0]       timer_d;
  logic             toggle;
  logic             req;

  assign dir        = dir_r;
  assign flip       = flip_r;
  assign busy       = busy_r;
  assign flip_count = cnt_r;

  // ---------------------------------------------------------------------------
  // Ground detection
  // ---------------------------------------------------------------------------
  function automatic logic [CMP_W-1:0] stand_height(input logic d, input int k);
    if (d) return CMP_W'(UP_OFFSET + k * PITCH);
    return CMP_W'(DN_OFFSET + k * PITCH);
  endfunction

  logic [CMP_W-1:0] height_ext;
  assign height_ext = CMP_W'(height);

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grounded = 1'b0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (lines[k] && (height_ext == stand_height(dir_r, k))) grounded = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign req = switch & ~switch_q;

  always_comb begin
    state_d = state;
    timer_d = timer;
    toggle  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (grounded) begin
            toggle  = 1'b1;
            state_d = FLIP_STATE;
            timer_d = FLIP_TIMER;
          end else begin
            state_d = S_BUFFERED;
            timer_d = BUF_RELOAD;
          end
        end
      end

      S_BUFFERED: begin
        // Landing wins over a fresh press in the same cycle.
        if (grounded) begin
          toggle  = 1'b1;
          state_d = FLIP_STATE;
          timer_d = FLIP_TIMER;
        end else if (req) begin
          timer_d = BUF_RELOAD;
        end else if (timer == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer - 8'd1;
        end
      end

      S_COOLDOWN: begin
        // Presses are dropped here, not buffered.
        if (timer <= 8'd1) begin
          state_d = S_IDLE;
          timer_d = 8'd0;
        end else begin
          timer_d = timer - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = 8'd0;
      end
    endcase

    // A dead player freezes everything; any edge seen now is lost because
    // switch_q still tracks the button.
    if (is_dead) begin
      state_d = state;
      timer_d = timer;
      toggle  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      timer <= 8'd0;
    end else begin
      state <= state_d;
      timer <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_r    <= 1'b0;
      flip_r   <= 1'b0;
      busy_r   <= 1'b0;
      cnt_r    <= '0;
      // A button held through reset must not look like a fresh press.
      switch_q <= 1'b1;
    end else begin
      switch_q <= switch;
      dir_r    <= dir_r ^ toggle;
      flip_r   <= toggle;
      busy_r   <= (state_d != S_IDLE);
      if (toggle && (cnt_r != '1)) cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule
